// File: rtl/phase_neuron_array.sv
// N_CH leaky integrate-and-fire neurons that code input strength as firing phase within a gamma cycle.
// Define PHASE_NEURON_ARRAY_WINNER_EN to add the first-firing channel outputs (winner_valid, winner_idx).
module phase_neuron_array #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 8,
    parameter int PHASE_W   = 8,
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 64,
    parameter int LEAK      = 8,
    parameter int REFRAC    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PHASE_W-1:0]        global_phase,
    input  logic                      cycle_start,
    input  logic                      mode,
    input  logic [N_CH-1:0]           ch_en,
    input  logic [N_CH*DATA_W-1:0]    input_current,
    output logic [N_CH-1:0]           spike_out,
    output logic [N_CH*PHASE_W-1:0]   phase_lock,
    output logic [N_CH-1:0]           fired_this_cycle,
    output logic [N_CH*CNT_W-1:0]     spike_count,
    output logic                      report_valid,
    output logic [N_CH*PHASE_W-1:0]   report_phase,
    output logic [N_CH-1:0]           report_fired
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
    ,
    output logic                      winner_valid,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] winner_idx
`endif
);
    localparam int RC_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

    typedef enum logic [1:0] {S_INTEG, S_REFRAC, S_DONE} state_t;

    state_t            st    [N_CH];
    logic [DATA_W-1:0] v_mem [N_CH];
    logic [RC_W-1:0]   rc    [N_CH];
    logic [DATA_W-1:0] b_p0  [N_CH];
    logic [N_CH-1:0]   fire_p0;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] leak_sub(input logic [DATA_W-1:0] s);
        return (s > DATA_W'(LEAK)) ? s - DATA_W'(LEAK) : '0;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // stage p0: leaky integration and threshold decision, cycle_start suppresses any fire
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            b_p0[i]    = leak_sub(sat_add(v_mem[i], input_current[i*DATA_W +: DATA_W]));
            fire_p0[i] = !cycle_start && ch_en[i] && (st[i] == S_INTEG) &&
                         (b_p0[i] >= DATA_W'(THRESHOLD));
        end
    end

`ifdef PHASE_NEURON_ARRAY_WINNER_EN
    localparam int WIN_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    logic [WIN_W-1:0] win_p0;

    always_comb begin
        win_p0 = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fire_p0[i]) win_p0 = WIN_W'(i);
        end
    end
`endif

    // stage p1: registered channel state, spikes and the end-of-cycle report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                st[i]    <= S_INTEG;
                v_mem[i] <= '0;
                rc[i]    <= '0;
            end
            spike_out        <= '0;
            phase_lock       <= '1;
            fired_this_cycle <= '0;
            spike_count      <= '0;
            report_valid     <= 1'b0;
            report_phase     <= '1;
            report_fired     <= '0;
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
            winner_valid     <= 1'b0;
            winner_idx       <= '0;
`endif
        end else if (cycle_start) begin
            report_phase     <= phase_lock;
            report_fired     <= fired_this_cycle;
            report_valid     <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                st[i]    <= S_INTEG;
                v_mem[i] <= '0;
                rc[i]    <= '0;
            end
            spike_out        <= '0;
            phase_lock       <= '1;
            fired_this_cycle <= '0;
            spike_count      <= '0;
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
            winner_valid     <= 1'b0;
            winner_idx       <= '0;
`endif
        end else begin
            report_valid <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                spike_out[i] <= fire_p0[i];
                if (!ch_en[i]) begin
                    st[i]    <= S_INTEG;
                    v_mem[i] <= '0;
                    rc[i]    <= '0;
                end else begin
                    case (st[i])
                        S_INTEG: begin
                            if (fire_p0[i]) begin
                                v_mem[i] <= '0;
                                spike_count[i*CNT_W +: CNT_W] <= cnt_inc(spike_count[i*CNT_W +: CNT_W]);
                                if (!fired_this_cycle[i]) begin
                                    phase_lock[i*PHASE_W +: PHASE_W] <= global_phase;
                                    fired_this_cycle[i]              <= 1'b1;
                                end
                                if (!mode) begin
                                    st[i] <= S_DONE;
                                end else if (REFRAC > 0) begin
                                    st[i] <= S_REFRAC;
                                    rc[i] <= RC_W'(REFRAC);
                                end
                            end else begin
                                v_mem[i] <= b_p0[i];
                            end
                        end
                        S_REFRAC: begin
                            v_mem[i] <= '0;
                            rc[i]    <= rc[i] - 1'b1;
                            if (rc[i] == RC_W'(1)) st[i] <= S_INTEG;
                        end
                        S_DONE: ;
                        default: st[i] <= S_INTEG;
                    endcase
                end
            end
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
            if (!winner_valid && (|fire_p0)) begin
                winner_valid <= 1'b1;
                winner_idx   <= win_p0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_phase_neuron_array.sv
// Self-checking bench for phase_neuron_array: directed scenarios plus random stimulus against a behavioural model.
module tb_phase_neuron_array;
    localparam int N_CH      = 4;
    localparam int DATA_W    = 8;
    localparam int PHASE_W   = 8;
    localparam int CNT_W     = 4;
    localparam int THRESHOLD = 64;
    localparam int LEAK      = 8;
    localparam int REFRAC    = 4;

    logic                    clk;
    logic                    rst_n;
    logic [PHASE_W-1:0]      global_phase;
    logic                    cycle_start;
    logic                    mode;
    logic [N_CH-1:0]         ch_en;
    logic [N_CH*DATA_W-1:0]  input_current;
    logic [N_CH-1:0]         spike_out;
    logic [N_CH*PHASE_W-1:0] phase_lock;
    logic [N_CH-1:0]         fired_this_cycle;
    logic [N_CH*CNT_W-1:0]   spike_count;
    logic                    report_valid;
    logic [N_CH*PHASE_W-1:0] report_phase;
    logic [N_CH-1:0]         report_fired;
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
    logic                    winner_valid;
    logic [1:0]              winner_idx;
`endif

    phase_neuron_array dut (
        .clk(clk), .rst_n(rst_n), .global_phase(global_phase), .cycle_start(cycle_start),
        .mode(mode), .ch_en(ch_en), .input_current(input_current), .spike_out(spike_out),
        .phase_lock(phase_lock), .fired_this_cycle(fired_this_cycle), .spike_count(spike_count),
        .report_valid(report_valid), .report_phase(report_phase), .report_fired(report_fired)
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
        , .winner_valid(winner_valid), .winner_idx(winner_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int phase;

    // behavioural model: membrane value, blocked-clock budget and "done for this cycle" flag per channel
    int m_v[N_CH], m_cnt[N_CH], m_lock[N_CH], m_block[N_CH], m_rphase[N_CH];
    bit m_fired[N_CH], m_done[N_CH], m_spike[N_CH], m_rfired[N_CH];
    bit m_rv, m_wv;
    int m_widx;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_v[i] = 0; m_cnt[i] = 0; m_lock[i] = 255; m_block[i] = 0; m_rphase[i] = 255;
            m_fired[i] = 0; m_done[i] = 0; m_spike[i] = 0; m_rfired[i] = 0;
        end
        m_rv = 0; m_wv = 0; m_widx = 0;
    endtask

    task automatic model_clock();
        int first, s, b;
        if (cycle_start) begin
            for (int i = 0; i < N_CH; i++) begin
                m_rphase[i] = m_lock[i]; m_rfired[i] = m_fired[i];
                m_v[i] = 0; m_cnt[i] = 0; m_lock[i] = 255; m_block[i] = 0;
                m_fired[i] = 0; m_done[i] = 0; m_spike[i] = 0;
            end
            m_rv = 1; m_wv = 0; m_widx = 0;
        end else begin
            m_rv = 0;
            first = -1;
            for (int i = 0; i < N_CH; i++) begin
                m_spike[i] = 0;
                if (!ch_en[i]) begin
                    m_v[i] = 0; m_block[i] = 0; m_done[i] = 0;
                end else if (m_done[i]) begin
                    m_v[i] = m_v[i];
                end else if (m_block[i] > 0) begin
                    m_block[i] = m_block[i] - 1; m_v[i] = 0;
                end else begin
                    s = m_v[i] + int'(input_current[i*DATA_W +: DATA_W]);
                    if (s > 255) s = 255;
                    b = (s > LEAK) ? s - LEAK : 0;
                    if (b >= THRESHOLD) begin
                        m_spike[i] = 1; m_v[i] = 0;
                        m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
                        if (!m_fired[i]) begin m_lock[i] = int'(global_phase); m_fired[i] = 1; end
                        if (!mode) m_done[i] = 1; else m_block[i] = REFRAC;
                        if (first < 0) first = i;
                    end else begin
                        m_v[i] = b;
                    end
                end
            end
            if (!m_wv && first >= 0) begin m_wv = 1; m_widx = first; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic start_cycle();
        cycle_start = 1'b1; global_phase = '0;
        step();
        cycle_start = 1'b0; phase = 1;
    endtask

    task automatic next_phase();
        global_phase = PHASE_W'(phase);
        step();
        phase = (phase + 1) % 256;
    endtask

    task automatic set_inputs(input int a, input int b, input int c, input int d);
        input_current = {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cycle_start = 1'b0; mode = 1'b0; ch_en = '1; global_phase = '0;
        set_inputs(0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (spike_out !== '0) begin miscompares++; $display("FAIL reset spike_out: got %h want 0", spike_out); end
        vectors++; if (phase_lock !== '1) begin miscompares++; $display("FAIL reset phase_lock: got %h want ffffffff", phase_lock); end
        vectors++; if (fired_this_cycle !== '0) begin miscompares++; $display("FAIL reset fired: got %h want 0", fired_this_cycle); end
        vectors++; if (spike_count !== '0) begin miscompares++; $display("FAIL reset spike_count: got %h want 0", spike_count); end
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL reset report_valid: got %b want 0", report_valid); end
        vectors++; if (report_phase !== '1) begin miscompares++; $display("FAIL reset report_phase: got %h want ffffffff", report_phase); end
        vectors++; if (report_fired !== '0) begin miscompares++; $display("FAIL reset report_fired: got %h want 0", report_fired); end
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
        vectors++; if (winner_valid !== 1'b0 || winner_idx !== 2'd0) begin miscompares++; $display("FAIL reset winner: got %b/%0d want 0/0", winner_valid, winner_idx); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_spike();
        mode = 1'b0; ch_en = '1; set_inputs(40, 0, 0, 0);
        start_cycle();
        next_phase();
        vectors++; if (spike_out !== 4'b0000) begin miscompares++; $display("FAIL first_spike early: got %b want 0000", spike_out); end
        next_phase();
        vectors++; if (spike_out !== 4'b0001) begin miscompares++; $display("FAIL first_spike pulse: got %b want 0001", spike_out); end
        vectors++; if (phase_lock[7:0] !== 8'd2) begin miscompares++; $display("FAIL first_spike lock: got %0d want 2", phase_lock[7:0]); end
        vectors++; if (spike_count[3:0] !== 4'd1) begin miscompares++; $display("FAIL first_spike count: got %0d want 1", spike_count[3:0]); end
        for (int p = 3; p <= 12; p++) begin
            next_phase();
            vectors++; if (spike_out[0] !== 1'b0 || spike_count[3:0] !== 4'd1) begin
                miscompares++; $display("FAIL first_spike hold p%0d: got spike %b cnt %0d want 0/1", p, spike_out[0], spike_count[3:0]);
            end
        end
    endtask

    task automatic test_multi_spike();
        int n, exp_cnt;
        bit exp_sp;
        mode = 1'b1; ch_en = '1; set_inputs(255, 0, 0, 0);
        start_cycle();
        for (int p = 1; p <= 80; p++) begin
            next_phase();
            exp_sp  = ((p - 1) % 5 == 0);
            n       = (p - 1) / 5 + 1;
            exp_cnt = (n > 15) ? 15 : n;
            vectors++; if (spike_out[0] !== exp_sp) begin miscompares++; $display("FAIL multi spike p%0d: got %b want %b", p, spike_out[0], exp_sp); end
            vectors++; if (int'(spike_count[3:0]) !== exp_cnt) begin miscompares++; $display("FAIL multi count p%0d: got %0d want %0d", p, spike_count[3:0], exp_cnt); end
            vectors++; if (phase_lock[7:0] !== 8'd1) begin miscompares++; $display("FAIL multi lock p%0d: got %0d want 1", p, phase_lock[7:0]); end
        end
    endtask

    task automatic test_leak_equal();
        mode = 1'b0; ch_en = '1; set_inputs(0, LEAK, 0, 0);
        start_cycle();
        for (int p = 1; p <= 255; p++) begin
            next_phase();
            if (p % 32 == 0) begin
                vectors++; if (fired_this_cycle[1] !== 1'b0) begin miscompares++; $display("FAIL leak fired p%0d: got 1 want 0", p); end
            end
        end
        start_cycle();
        vectors++; if (report_valid !== 1'b1) begin miscompares++; $display("FAIL leak report_valid: got %b want 1", report_valid); end
        vectors++; if (report_fired[1] !== 1'b0) begin miscompares++; $display("FAIL leak report_fired: got %b want 0", report_fired[1]); end
        vectors++; if (report_phase[15:8] !== 8'd255) begin miscompares++; $display("FAIL leak report_phase: got %0d want 255", report_phase[15:8]); end
        next_phase();
        vectors++; if (report_valid !== 1'b0) begin miscompares++; $display("FAIL leak report_valid pulse: got %b want 0", report_valid); end
    endtask

    task automatic test_cycle_start_priority();
        mode = 1'b1; ch_en = '1; set_inputs(40, 0, 0, 0);
        start_cycle();
        for (int p = 1; p <= 7; p++) next_phase();
        start_cycle();
        vectors++; if (spike_out !== 4'b0000) begin miscompares++; $display("FAIL cs_prio spike: got %b want 0000", spike_out); end
        vectors++; if (report_fired[0] !== 1'b1) begin miscompares++; $display("FAIL cs_prio report_fired: got %b want 1", report_fired[0]); end
        vectors++; if (report_phase[7:0] !== 8'd2) begin miscompares++; $display("FAIL cs_prio report_phase: got %0d want 2", report_phase[7:0]); end
        vectors++; if (spike_count !== '0 || fired_this_cycle !== '0) begin miscompares++; $display("FAIL cs_prio clear: got cnt %h fired %h want 0/0", spike_count, fired_this_cycle); end
        vectors++; if (phase_lock !== '1) begin miscompares++; $display("FAIL cs_prio lock: got %h want ffffffff", phase_lock); end
        next_phase();
        vectors++; if (spike_out[0] !== 1'b0) begin miscompares++; $display("FAIL cs_prio restart p1: got %b want 0", spike_out[0]); end
        next_phase();
        vectors++; if (spike_out[0] !== 1'b1) begin miscompares++; $display("FAIL cs_prio restart p2: got %b want 1", spike_out[0]); end
    endtask

    task automatic test_reset_mid_cycle();
        mode = 1'b1; ch_en = '1; set_inputs(255, 0, 0, 0);
        start_cycle();
        next_phase();
        next_phase();
        rst_n = 1'b0;
        #1;
        vectors++; if (spike_out !== '0 || fired_this_cycle !== '0 || spike_count !== '0) begin
            miscompares++; $display("FAIL midreset ctrl: got sp %h fired %h cnt %h want 0", spike_out, fired_this_cycle, spike_count);
        end
        vectors++; if (phase_lock !== '1 || report_phase !== '1) begin
            miscompares++; $display("FAIL midreset phases: got %h %h want all ones", phase_lock, report_phase);
        end
        vectors++; if (report_valid !== 1'b0 || report_fired !== '0) begin
            miscompares++; $display("FAIL midreset report: got %b %h want 0", report_valid, report_fired);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(40, 0, 0, 0);
        next_phase();
        vectors++; if (spike_out[0] !== 1'b0 || report_valid !== 1'b0) begin miscompares++; $display("FAIL midreset p3: got sp %b rv %b want 0/0", spike_out[0], report_valid); end
        next_phase();
        vectors++; if (spike_out[0] !== 1'b1 || report_valid !== 1'b0) begin miscompares++; $display("FAIL midreset p4: got sp %b rv %b want 1/0", spike_out[0], report_valid); end
        vectors++; if (phase_lock[7:0] !== 8'd4) begin miscompares++; $display("FAIL midreset lock: got %0d want 4", phase_lock[7:0]); end
    endtask

`ifdef PHASE_NEURON_ARRAY_WINNER_EN
    task automatic test_winner();
        mode = 1'b0; ch_en = '1; set_inputs(40, 255, 255, 0);
        start_cycle();
        vectors++; if (winner_valid !== 1'b0) begin miscompares++; $display("FAIL winner start: got %b want 0", winner_valid); end
        next_phase();
        vectors++; if (winner_valid !== 1'b1 || winner_idx !== 2'd1) begin miscompares++; $display("FAIL winner p1: got %b/%0d want 1/1", winner_valid, winner_idx); end
        next_phase();
        vectors++; if (winner_valid !== 1'b1 || winner_idx !== 2'd1) begin miscompares++; $display("FAIL winner p2: got %b/%0d want 1/1", winner_valid, winner_idx); end
        start_cycle();
        vectors++; if (winner_valid !== 1'b0 || winner_idx !== 2'd0) begin miscompares++; $display("FAIL winner clear: got %b/%0d want 0/0", winner_valid, winner_idx); end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 49) == 0) mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 29) == 0) ch_en[i] = ~ch_en[i];
                input_current[i*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ?
                    DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 59) == 0) start_cycle();
            else next_phase();
            for (int i = 0; i < N_CH; i++) begin
                vectors++; if (spike_out[i] !== m_spike[i]) begin miscompares++; $display("FAIL rnd spike t%0d ch%0d: got %b want %b", t, i, spike_out[i], m_spike[i]); end
                vectors++; if (int'(phase_lock[i*PHASE_W +: PHASE_W]) !== m_lock[i]) begin miscompares++; $display("FAIL rnd lock t%0d ch%0d: got %0d want %0d", t, i, phase_lock[i*PHASE_W +: PHASE_W], m_lock[i]); end
                vectors++; if (fired_this_cycle[i] !== m_fired[i]) begin miscompares++; $display("FAIL rnd fired t%0d ch%0d: got %b want %b", t, i, fired_this_cycle[i], m_fired[i]); end
                vectors++; if (int'(spike_count[i*CNT_W +: CNT_W]) !== m_cnt[i]) begin miscompares++; $display("FAIL rnd count t%0d ch%0d: got %0d want %0d", t, i, spike_count[i*CNT_W +: CNT_W], m_cnt[i]); end
                vectors++; if (int'(report_phase[i*PHASE_W +: PHASE_W]) !== m_rphase[i] || report_fired[i] !== m_rfired[i]) begin
                    miscompares++; $display("FAIL rnd report t%0d ch%0d: got %0d/%b want %0d/%b", t, i, report_phase[i*PHASE_W +: PHASE_W], report_fired[i], m_rphase[i], m_rfired[i]);
                end
            end
            vectors++; if (report_valid !== m_rv) begin miscompares++; $display("FAIL rnd report_valid t%0d: got %b want %b", t, report_valid, m_rv); end
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
            vectors++; if (winner_valid !== m_wv || int'(winner_idx) !== m_widx) begin
                miscompares++; $display("FAIL rnd winner t%0d: got %b/%0d want %b/%0d", t, winner_valid, winner_idx, m_wv, m_widx);
            end
`endif
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        phase = 0;
        test_reset();
        test_first_spike();
        test_multi_spike();
        test_leak_equal();
        test_cycle_start_priority();
        test_reset_mid_cycle();
`ifdef PHASE_NEURON_ARRAY_WINNER_EN
        test_winner();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_neuron_array.md
Name: phase_neuron_array

Overview:
- N_CH-channel phase-coding neuron bank for the PST attention path, driven by the shared gamma oscillator (global_phase, cycle_start).
- Each channel converts input strength to firing phase: stronger input fires earlier in the gamma cycle.
- Successor to the single-channel phase neuron, adding:
  - a real per-clock leak
  - a multi-spike mode with refractory period
  - per-channel enable
  - saturating spike counters
  - an end-of-cycle report snapshot consumed by the coincidence-detector stage

Parameters:
- N_CH, 4, number of neuron channels
- DATA_W, 8, input_current / membrane width
- PHASE_W, 8, global_phase / phase_lock width
- CNT_W, 4, per-channel spike counter width
- THRESHOLD, 64, firing threshold (DATA_W bits)
- LEAK, 8, amount subtracted from membrane every integrating clock
- REFRAC, 4, refractory clocks after a spike in mode 1 (0 = none)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- global_phase  in  PHASE_W  current gamma phase
- cycle_start  in  1  one-clock pulse marking gamma cycle start
- mode  in  1  0 = first-spike only, 1 = multi-spike with refractory
- ch_en  in  N_CH  per-channel enable
- input_current  in  N_CH*DATA_W  packed; channel i at [i*DATA_W +: DATA_W]
- spike_out  out  N_CH  one-clock spike pulses
- phase_lock  out  N_CH*PHASE_W  phase of first spike this cycle
- fired_this_cycle  out  N_CH  channel has spiked this cycle
- spike_count  out  N_CH*CNT_W  spikes this cycle, saturating
- report_valid  out  1  one-clock pulse after cycle_start
- report_phase  out  N_CH*PHASE_W  previous cycle's phase_lock snapshot
- report_fired  out  N_CH  previous cycle's fired_this_cycle snapshot

Behaviour:
- Reset values:
  - all outputs 0, except phase_lock and report_phase all-ones
  - v_mem 0; every channel state INTEG
- Per-channel states:
  - INTEG
  - REFRAC (down-counter rc)
  - DONE
- INTEG update, each clock with cycle_start=0 and ch_en[i]=1:
  - s = min(v_mem + in_i, 2^DATA_W-1)
  - b = (s > LEAK) ? s - LEAK : 0
  - if b >= THRESHOLD, fire; otherwise v_mem <= b
- Fire (registered; spike_out high the clock after the crossing clock):
  - v_mem <= 0; count <= min(count+1, 2^CNT_W-1)
  - if fired_this_cycle=0: phase_lock <= global_phase sampled in the crossing clock; fired_this_cycle <= 1
  - mode=0: go to DONE
  - mode=1 and REFRAC>0: go to REFRAC with rc=REFRAC
  - mode=1 and REFRAC=0: stay in INTEG
- REFRAC: no integration, v_mem held 0; rc decrements each clock; at rc==1 next state is INTEG.
- DONE: hold all channel registers until cycle_start.
- ch_en[i]=0: v_mem forced 0, state INTEG, no fire; counters and phase_lock retained.
- mode is sampled every clock. Changing mode mid-cycle affects only subsequent fire decisions.
- cycle_start (highest priority; that clock's input is ignored, even if it would cross threshold):
  - report_phase <= phase_lock; report_fired <= fired_this_cycle
  - report_valid <= 1 for one clock
  - all channels: INTEG, v_mem 0, count 0, fired 0, phase_lock all-ones, spike_out 0
- Channels are independent. Simultaneous fires on multiple channels are all honoured.
- Reset asserted mid-cycle: all state returns to reset values immediately; no report is generated.

Optional Feature:
- Macro: PHASE_NEURON_ARRAY_WINNER_EN
- With macro defined, add two outputs:
  - winner_valid (1)
  - winner_idx ($clog2(N_CH), minimum 1 bit)
- Winner selection:
  - on the first clock in which any channel fires in a gamma cycle, winner_idx <= lowest-index firing channel and winner_valid <= 1
  - both hold until cycle_start, which clears them to 0
  - later fires never change the winner
- Without macro: ports and logic absent.

Test Plan:
1. Defaults, mode=0, ch0 in=40, cycle_start at phase 0, then phases 1, 2, … → crossing at phase 2 (32, then 64): spike_out[0] high one clock later, phase_lock[0]=2, count=1, no further spikes.
2. mode=1, ch0 in=255 → crossings at phases 1, 6, 11, 16, …; phase_lock stays 1; count saturates at 15 and holds.
3. ch1 in=8 (equals LEAK) for a full cycle → never fires. At next cycle_start: report_valid=1, report_fired[1]=0, report_phase[1]=255.
4. cycle_start coincides with a clock where ch0 would cross → no spike. report_fired[0] and report_phase[0] show the previous cycle; counters cleared.
5. rst_n low mid-cycle while ch0 is in REFRAC → immediate reset values; after release, integration restarts from v_mem=0 and report_valid stays 0.
6. WINNER_EN: ch0 in=40, ch1 in=255, ch2 in=255 → winner_idx=1 and winner_valid=1 after phase 1; unchanged when ch0 fires at phase 2; cleared at cycle_start.
